// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the RV32 core: shares one word-wide memory port between
// instruction fetch and data access, with lane steering, load extension and fetch-starvation guard.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state_o
);

    // Handshake: requesters hold req until their done pulse; memory sees mem_req held
    // with stable mem_* until a single-cycle mem_ack, which completes the access.

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        D_ERR  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  a_q, a_d;

    logic        d_req;
    logic        d_store;
    logic        d_legal;
    logic        fetch_wins;
    logic [1:0]  d_a;
    logic [3:0]  d_be;
    logic [31:0] d_wlane;
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;
    logic        unused_if_addr_lsb;

    assign d_req              = d_read | d_write;
    assign d_store            = d_write;
    assign d_a                = d_addr[1:0];
    assign unused_if_addr_lsb = ^if_addr[1:0];
    assign fetch_wins         = if_req && (!d_req || (starve_q == LIMIT));

    always_comb begin
        d_legal = 1'b0;
        case (d_funct3)
            3'b000:         d_legal = 1'b1;
            3'b001:         d_legal = ~d_a[0];
            3'b010:         d_legal = (d_a == 2'b00);
            3'b100:         d_legal = ~d_store;
            3'b101:         d_legal = ~d_store & ~d_a[0];
            default:        d_legal = 1'b0;
        endcase
    end

    // Stores replicate the datum across the word so the enabled lanes carry it.
    always_comb begin
        d_be    = 4'hF;
        d_wlane = d_wdata;
        case (d_funct3[1:0])
            2'b00: begin
                d_be    = 4'b0001 << d_a;
                d_wlane = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                d_be    = 4'b0011 << d_a;
                d_wlane = {2{d_wdata[15:0]}};
            end
            default: begin
                d_be    = 4'hF;
                d_wlane = d_wdata;
            end
        endcase
        if (!d_store) begin
            d_be = 4'hF;
        end
    end

    assign ld_shift = mem_rdata >> {a_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
            3'b101:  ld_ext = {16'd0, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        be_d     = be_q;
        f3_d     = f3_q;
        a_d      = a_q;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    if (fetch_wins) begin
                        state_d  = BUSY_I;
                        starve_d = 4'd0;
                        addr_d   = {if_addr[31:2], 2'b00};
                        we_d     = 1'b0;
                        be_d     = 4'hF;
                    end else begin
                        // Only data grants made while fetch waits count toward starvation.
                        if (if_req) begin
                            starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
                        end else begin
                            starve_d = 4'd0;
                        end
                        if (d_legal) begin
                            state_d = BUSY_D;
                            addr_d  = {d_addr[31:2], 2'b00};
                            we_d    = d_store;
                            be_d    = d_be;
                            wdata_d = d_store ? d_wlane : 32'd0;
                            f3_d    = d_funct3;
                            a_d     = d_a;
                        end else begin
                            state_d = D_ERR;
                        end
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            D_ERR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
            be_q     <= 4'd0;
            f3_q     <= 3'd0;
            a_q      <= 2'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            be_q     <= be_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
        end
    end

    assign mem_req     = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_be      = be_q;
    assign if_done     = (state_q == BUSY_I) && mem_ack;
    assign if_rdata    = if_done ? mem_rdata : 32'd0;
    assign d_done      = ((state_q == BUSY_D) && mem_ack) || (state_q == D_ERR);
    assign d_err       = (state_q == D_ERR);
    assign d_rdata     = ((state_q == BUSY_D) && mem_ack && !we_q) ? ld_ext : 32'd0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: drivers push expected completions and memory-side
// requests into queues; a memory responder and a completion monitor pop and compare.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } mem_item_t;

    logic        clk, rst;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_rdata;
    logic        d_read, d_write, d_done, d_err;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [1:0]  dbg_state;

    logic [33:0] exp_q[$];
    mem_item_t   mem_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_done = 0;
    int          mem_wait = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_read(d_read), .d_write(d_write), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Memory responder: checks request fields every cycle mem_req is up, acks after mem_wait cycles.
    initial begin
        mem_item_t h;
        int wcnt;
        wcnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk); #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                mem_rdata = 32'd0;
            end else if (mem_req) begin
                checks++;
                if (mem_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_mem_req addr=%h", mem_addr);
                end else begin
                    h = mem_q[0];
                    if (mem_addr !== h.addr || mem_we !== h.we || mem_be !== h.be ||
                        (h.we && mem_wdata !== h.wdata)) begin
                        errors++;
                        $display("FAIL mem_side got addr=%h we=%b be=%h wdata=%h exp addr=%h we=%b be=%h wdata=%h",
                                 mem_addr, mem_we, mem_be, mem_wdata, h.addr, h.we, h.be, h.wdata);
                    end
                    if (wcnt == mem_wait) begin
                        mem_ack = 1'b1;
                        mem_rdata = h.rdata;
                        void'(mem_q.pop_front());
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Completion monitor: {is_data, err, rdata} compared in issue order.
    initial begin
        logic [33:0] got, e;
        forever begin
            @(negedge clk); #2;
            if (d_done || if_done) begin
                n_done++;
                got = {d_done, d_err, d_done ? d_rdata : if_rdata};
                checks++;
                if (d_done && if_done) begin
                    errors++;
                    $display("FAIL both_done got=%h exp=single", got);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got=%h exp=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL completion got=%h exp=%h", got, e);
                    end
                end
            end else begin
                check("idle_outputs_zero", {d_err, 1'b0, d_rdata | if_rdata}, 34'd0);
            end
        end
    end

    task automatic do_data(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mrd,
                           input logic exp_err, input logic [31:0] exp_rd, input logic [3:0] exp_be,
                           input logic [31:0] exp_mwd, input int exp_lat);
        mem_item_t m;
        int cnt;
        logic seen;
        exp_q.push_back({1'b1, exp_err, exp_rd});
        if (!exp_err) begin
            m.addr = {addr[31:2], 2'b00};
            m.we = wr;
            m.be = exp_be;
            m.wdata = exp_mwd;
            m.rdata = mrd;
            mem_q.push_back(m);
        end
        @(posedge clk); #1;
        d_read = rd; d_write = wr; d_funct3 = f3; d_addr = addr; d_wdata = wd;
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 50) begin
            @(negedge clk); #3;
            cnt++;
            if (d_done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL data_timeout addr=%h got=no_done exp=done", addr);
        end else if (cnt - 1 != exp_lat) begin
            errors++;
            $display("FAIL data_latency addr=%h got=%0d exp=%0d", addr, cnt - 1, exp_lat);
        end
        @(posedge clk); #1;
        d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] mrd, input int exp_lat);
        mem_item_t m;
        int cnt;
        logic seen;
        exp_q.push_back({2'b00, mrd});
        m.addr = {addr[31:2], 2'b00};
        m.we = 1'b0;
        m.be = 4'hF;
        m.wdata = 32'd0;
        m.rdata = mrd;
        mem_q.push_back(m);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = addr;
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 50) begin
            @(negedge clk); #3;
            cnt++;
            if (if_done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL fetch_timeout addr=%h got=no_done exp=done", addr);
        end else if (cnt - 1 != exp_lat) begin
            errors++;
            $display("FAIL fetch_latency got=%0d exp=%0d", cnt - 1, exp_lat);
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        mem_item_t m;
        int cnt, base;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        d_read = 1'b0; d_write = 1'b0; d_funct3 = 3'd0; d_addr = 32'd0; d_wdata = 32'd0;
        #3;
        check("rst_mem_req", {33'd0, mem_req}, 34'd0);
        check("rst_mem_addr", {2'b0, mem_addr}, 34'd0);
        check("rst_mem_be_we", {29'd0, mem_be, mem_we}, 34'd0);
        check("rst_mem_wdata", {2'b0, mem_wdata}, 34'd0);
        check("rst_done", {30'd0, d_done, d_err, if_done, 1'b0}, 34'd0);
        check("rst_state", {32'd0, dbg_state}, 34'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        mem_wait = 1;
        do_data(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 4'hF, 32'h0, 2);
        mem_wait = 0;
        do_data(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 32'hFFFFFF80, 4'hF, 32'h0, 1);
        do_data(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 32'h00000080, 4'hF, 32'h0, 1);
        do_data(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 0, 32'h0, 4'b1100, 32'hABCDABCD, 1);
        do_data(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 32'h0, 4'hF, 32'h0, 1);
        do_data(1, 0, 3'b001, 32'h102, 32'h0, 32'h80011234, 0, 32'hFFFF8001, 4'hF, 32'h0, 1);
        do_data(1, 0, 3'b101, 32'h102, 32'h0, 32'h80011234, 0, 32'h00008001, 4'hF, 32'h0, 1);
        do_data(0, 1, 3'b000, 32'h101, 32'h123456A5, 32'h0, 0, 32'h0, 4'b0010, 32'hA5A5A5A5, 1);
        do_data(0, 1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0, 0, 32'h0, 4'hF, 32'hCAFEF00D, 1);
        do_data(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 32'h0, 4'hF, 32'h0, 1);
        do_data(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 1, 32'h0, 4'hF, 32'h0, 1);
        do_data(0, 1, 3'b001, 32'h103, 32'h0, 32'h0, 1, 32'h0, 4'hF, 32'h0, 1);
        do_data(1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 1, 32'h0, 4'hF, 32'h0, 1);
        do_data(1, 0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 32'h0000007F, 4'hF, 32'h0, 1);
        do_data(1, 1, 3'b010, 32'h108, 32'h11223344, 32'h0, 0, 32'h0, 4'hF, 32'h11223344, 1);
        do_fetch(32'h203, 32'h00000013, 1);
        mem_wait = 3;
        do_data(1, 0, 3'b010, 32'h104, 32'h0, 32'h12345678, 0, 32'h12345678, 4'hF, 32'h0, 4);

        // Starvation guard: both requesters held, expected order D,D,D,D,I,D,D,D,D,I.
        mem_wait = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) begin
                exp_q.push_back({2'b00, 32'hB0000000 + 32'(k)});
                m.addr = 32'h200; m.we = 1'b0; m.be = 4'hF; m.wdata = 32'h0;
                m.rdata = 32'hB0000000 + 32'(k);
            end else begin
                exp_q.push_back({2'b10, 32'hA0000000 + 32'(k)});
                m.addr = 32'h300; m.we = 1'b0; m.be = 4'hF; m.wdata = 32'h0;
                m.rdata = 32'hA0000000 + 32'(k);
            end
            mem_q.push_back(m);
        end
        base = n_done;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h200;
        d_read = 1'b1; d_funct3 = 3'b010; d_addr = 32'h300;
        cnt = 0;
        while (n_done < base + 10 && cnt < 100) begin
            @(negedge clk); #3;
            cnt++;
        end
        check("starve_done_count", 34'(n_done - base), 34'd10);
        @(posedge clk); #1;
        if_req = 1'b0; d_read = 1'b0;

        // Asynchronous reset while a load waits on a slow memory.
        mem_wait = 5;
        m.addr = 32'h400; m.we = 1'b0; m.be = 4'hF; m.wdata = 32'h0; m.rdata = 32'h5555;
        mem_q.push_back(m);
        @(posedge clk); #1;
        d_read = 1'b1; d_funct3 = 3'b010; d_addr = 32'h400;
        repeat (2) @(posedge clk);
        #3;
        check("busy_before_rst", {33'd0, mem_req}, 34'd1);
        rst = 1'b1;
        d_read = 1'b0;
        #1;
        check("rst_async_mem_req", {33'd0, mem_req}, 34'd0);
        check("rst_async_done", {32'd0, d_done, if_done}, 34'd0);
        mem_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h5555;
        #2;
        check("late_ack_ignored", {31'd0, d_done, if_done, mem_req}, 34'd0);
        mem_wait = 0;
        do_data(1, 0, 3'b010, 32'h404, 32'h0, 32'h600DCAFE, 0, 32'h600DCAFE, 4'hF, 32'h0, 1);

        repeat (4) @(posedge clk);
        check("exp_q_drained", 34'(exp_q.size()), 34'd0);
        check("mem_q_drained", 34'(mem_q.size()), 34'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter and sequencer for the RV32 core. It shares one word-wide memory port between the instruction-fetch stage and the data-access stage, which is driven by the decoder's MemRead/MemWrite and funct3. It builds byte enables and aligns store data, sign- or zero-extends load data, and flags misaligned or illegal data accesses. It prevents fetch starvation with a bounded data-priority counter.

## Interface
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch is pending; the next grant then goes to fetch (1..15).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  32  fetch address; bits [1:0] ignored (forced 0).
- if_done  out  1  fetch complete this cycle; if_rdata valid.
- if_rdata  out  32  fetched word; 0 when if_done=0.
- d_read  in  1  load request (decoder MemRead); held until d_done.
- d_write  in  1  store request (decoder MemWrite); wins if d_read is also high.
- d_funct3  in  3  access size/sign, RV32 load/store encoding.
- d_addr  in  32  byte address.
- d_wdata  in  32  store data, LSB-aligned.
- d_done  out  1  data access complete this cycle.
- d_err  out  1  with d_done: access rejected (misaligned/illegal funct3); no memory access performed.
- d_rdata  out  32  extended load result; 0 unless d_done && !d_err on a load.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_wdata  out  32  store data shifted to byte lane.
- mem_be  out  4  byte enables (all ones for reads).
- mem_ack  in  1  one-cycle completion pulse; mem_rdata valid with it on reads.
- mem_rdata  in  32  read word.

## Operation
- States: IDLE, BUSY_I, BUSY_D, D_ERR. Reset: IDLE, starve_cnt=0, every output 0.
- IDLE with no request: stay.
- IDLE with a request: the grant is evaluated from that cycle's inputs. Data is requested if d_read|d_write.
  - Data wins over fetch unless if_req && starve_cnt==STARVE_LIMIT.
  - Fetch grant: go to BUSY_I; register mem_addr, mem_we=0, mem_be=4'hF.
  - Data grant, legal access: go to BUSY_D; register addr, we, be, wdata, plus funct3 and addr[1:0] for load extraction.
  - Data grant, illegal access: go to D_ERR.
- starve_cnt update at a grant:
  - Data grant with if_req high: saturating increment.
  - Fetch grant: clear to 0.
  - Data grant with if_req low: clear to 0.
- Legality:
  - Loads: funct3 ∈ {000,001,010,100,101}.
  - Stores: funct3 ∈ {000,001,010}.
  - Halfword requires addr[0]=0; word requires addr[1:0]=0.
- Byte enables and store data:
  - Byte: be=4'b0001<<a, wdata={4{wdata[7:0]}}.
  - Half: be=4'b0011<<a, wdata={2{wdata[15:0]}}.
  - Word: be=4'hF.
  - Here a=addr[1:0].
- Load extraction from mem_rdata >> (8*a_reg): LB/LH sign-extend, LBU/LHU zero-extend, LW pass through.
- mem_req is high exactly in BUSY_I and BUSY_D. mem_ack in IDLE or D_ERR is ignored.
- BUSY_x with mem_ack: the matching x_done=1 combinationally in the same cycle; next state IDLE.
- D_ERR: d_done=1 and d_err=1 for one cycle; next state IDLE.
- Requester protocol: req is held through the done cycle. A req high in the cycle after done is a new transaction.

## Timing
- Request seen in IDLE at cycle N → mem_req/addr/be registered high from N+1 → mem_ack at M≥N+1 → done at M → IDLE at M+1.
- Minimum 2 cycles per access. Back-to-back throughput is one access per 2 cycles at zero memory wait.
- Error path: request at N → d_done/d_err at N+1.
- mem_* outputs are stable from N+1 until the ack cycle inclusive.
- Asynchronous rst mid-transaction: immediate return to IDLE, mem_req=0, done outputs 0, starve_cnt=0. A late mem_ack after reset is ignored.

## Test plan
- LW, addr 0x100, mem_rdata 0xDEADBEEF with ack one cycle after mem_req → mem_be=F, mem_addr=0x100; d_done and d_rdata=0xDEADBEEF two cycles after request.
- LB at 0x103 with mem_rdata=0x80112233 → d_rdata=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x102, wdata 0x0000ABCD → mem_we=1, mem_be=4'b1100, mem_wdata=0xABCDABCD.
- LW at 0x101 → d_done=d_err=1 one cycle after the request; mem_req never asserts.
- if_req and d_read held continuously, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I…
- rst pulsed while in BUSY_D waiting on ack → mem_req=0 at once; subsequent mem_ack produces no done; next request is serviced normally.
